// File: rtl/multi_sensor_ctrl.sv
// Multi-channel sensor capture controller: each channel fills its own bank of
// DEPTH words and raises a sticky interrupt on full or on reaching a watermark.
module multi_sensor_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int NUM_CH = 2,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            sctrl_en,
    input  logic [NUM_CH-1:0]            sctrl_clear,
    input  logic                         sctrl_wm_mode,
    input  logic [ADDR_W:0]              sctrl_wm,
    input  logic [CH_W-1:0]              sctrl_ch,
    input  logic [ADDR_W-1:0]            sctrl_addr,
    input  logic [NUM_CH-1:0]            sensor_ready,
    input  logic [NUM_CH*DATA_W-1:0]     sensor_out,
    output logic [NUM_CH-1:0]            sensor_en,
    output logic                         sctrl_interrupt,
    output logic [NUM_CH-1:0]            sctrl_irq,
    output logic [NUM_CH-1:0]            sctrl_ovf,
    output logic [NUM_CH*(ADDR_W+1)-1:0] sctrl_count,
    output logic [DATA_W-1:0]            sctrl_out
);
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_FULL} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [CH_W:0]   CH_LIMIT = (CH_W+1)'(NUM_CH);

    logic [ADDR_W:0]   wm_level;
    logic [NUM_CH-1:0] irq_next;
    logic [DATA_W-1:0] rd_data [NUM_CH];
    logic              interrupt_q;
    logic [DATA_W-1:0] out_q;

    // A programmed watermark of zero means "interrupt only when full".
    assign wm_level = (sctrl_wm == '0) ? FULL_CNT : sctrl_wm;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t            state_q, state_d;
        logic [ADDR_W:0]   count_q, count_d;
        logic              irq_q, irq_d;
        logic              ovf_q, ovf_d;
        logic              en_q;
        logic              hit;
        logic              we;
        logic [DATA_W-1:0] bank [DEPTH];

        assign hit = sctrl_wm_mode ? (count_q >= wm_level) : (count_q == FULL_CNT);

        always_comb begin
            // NOTE: every signal gets a default before any branch, so no path can infer a latch.
            state_d = state_q;
            count_d = count_q;
            irq_d   = irq_q | hit;
            ovf_d   = ovf_q;
            we      = 1'b0;
            if (sctrl_clear[g]) begin
                state_d = ST_IDLE;
                count_d = '0;
                irq_d   = 1'b0;
                ovf_d   = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sctrl_en[g] && (count_q < FULL_CNT)) state_d = ST_FILL;
                    end
                    ST_FILL: begin
                        if (sensor_ready[g]) begin
                            we      = 1'b1;
                            count_d = count_q + 1'b1;
                        end
                        if (count_d == FULL_CNT) state_d = ST_FULL;
                        else if (!sctrl_en[g])   state_d = ST_IDLE;
                    end
                    ST_FULL: begin
                        if (sensor_ready[g]) ovf_d = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q <= ST_IDLE;
                count_q <= '0;
                irq_q   <= 1'b0;
                ovf_q   <= 1'b0;
                en_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                irq_q   <= irq_d;
                ovf_q   <= ovf_d;
                en_q    <= (state_d == ST_FILL);
            end
        end

        // NOTE: bank storage has no reset so it maps onto plain RAM; contents survive rstn.
        always_ff @(posedge clk) begin
            if (we) bank[count_q[ADDR_W-1:0]] <= sensor_out[g*DATA_W +: DATA_W];
        end

        assign rd_data[g]                             = bank[sctrl_addr];
        assign irq_next[g]                            = irq_d;
        assign sensor_en[g]                           = en_q;
        assign sctrl_irq[g]                           = irq_q;
        assign sctrl_ovf[g]                           = ovf_q;
        assign sctrl_count[g*(ADDR_W+1) +: ADDR_W+1] = count_q;
    end

    // Readout register samples the bank before this edge's write: read-old-data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            interrupt_q <= 1'b0;
            out_q       <= '0;
        end else begin
            interrupt_q <= |irq_next;
            out_q       <= ({1'b0, sctrl_ch} < CH_LIMIT) ? rd_data[sctrl_ch] : '0;
        end
    end

    assign sctrl_interrupt = interrupt_q;
    assign sctrl_out       = out_q;
endmodule

// File: doc/multi_sensor_ctrl.md
Name: multi_sensor_ctrl

Overview:
- Parametrised successor to the single-channel sensor controller.
- Captures samples from NUM_CH independent sensors into per-channel buffer banks of DEPTH words.
- Raises a per-channel interrupt when the channel's buffer reaches a programmable watermark, or when it is full.
- Sits in the DRAM clock domain between the external sensors and the core-side sctrl_* interface.

Parameters:
DATA_W, 32, sample/readout width
DEPTH, 512, words per channel bank (power of two, >=4)
NUM_CH, 2, number of sensor channels (1..8)
ADDR_W, $clog2(DEPTH), bank address width
CH_W, (NUM_CH>1)?$clog2(NUM_CH):1, channel select width

Ports:
clk  input  1  controller clock (single clock domain)
rstn  input  1  asynchronous active-low reset
sctrl_en  input  NUM_CH  per-channel capture enable from core
sctrl_clear  input  NUM_CH  per-channel buffer clear pulse (1 cycle)
sctrl_wm_mode  input  1  0: interrupt on full; 1: interrupt on count>=sctrl_wm
sctrl_wm  input  ADDR_W+1  watermark level (1..DEPTH)
sctrl_ch  input  CH_W  readout channel select
sctrl_addr  input  ADDR_W  readout word address
sensor_ready  input  NUM_CH  per-channel sample valid
sensor_out  input  NUM_CH*DATA_W  per-channel sample; channel c at [c*DATA_W +: DATA_W]
sensor_en  output  NUM_CH  per-channel request to sensor
sctrl_interrupt  output  1  OR of sctrl_irq
sctrl_irq  output  NUM_CH  per-channel interrupt
sctrl_ovf  output  NUM_CH  sticky overrun flag
sctrl_count  output  NUM_CH*(ADDR_W+1)  per-channel stored-word count
sctrl_out  output  DATA_W  readout data, registered

Behaviour:
- Reset (rstn=0, asynchronous): all channels IDLE; count=0; sensor_en=0; sctrl_irq=0; sctrl_interrupt=0; sctrl_ovf=0; sctrl_out=0. Bank contents are not reset.
- Per-channel FSM:
  - IDLE -> FILL when sctrl_en[c]=1 and count<DEPTH.
  - FILL -> FULL when a write makes count==DEPTH.
  - FILL -> IDLE when sctrl_en[c]=0; count is retained.
  - FULL -> IDLE only via sctrl_clear[c].
- sensor_en[c]: registered; 1 exactly while state==FILL.
- Capture: in FILL, when sensor_ready[c]=1, the sample is written to bank[c][count[ADDR_W-1:0]] and count increments on the same edge. One sample per cycle per channel maximum. Channels are fully independent.
- sensor_ready[c] while not in FILL: sample dropped. It sets sctrl_ovf[c] only if state==FULL. The flag is sticky until sctrl_clear[c].
- Clear: sctrl_clear[c] on edge sets count=0, irq[c]=0, ovf[c]=0, and state=IDLE. The FSM re-enters FILL the next cycle if sctrl_en[c] is still 1.
  - Clear and sensor_ready in the same cycle: clear wins and the sample is discarded; ovf is not set.
- Interrupt:
  - sctrl_irq[c] is registered, level, and is set the cycle after the condition becomes true.
  - Mode 0 condition: count==DEPTH. Mode 1 condition: count>=sctrl_wm.
  - sctrl_wm=0 is treated as DEPTH.
  - The interrupt remains asserted until sctrl_clear[c], even if the mode or watermark changes.
  - sctrl_interrupt is the registered OR of the post-update irq bits, so it asserts in the same cycle as sctrl_irq.
- Readout:
  - sctrl_out = bank[sctrl_ch][sctrl_addr], one-cycle latency.
  - Readout is permitted in any state. A write and a read to the same word in the same cycle returns the old data.
  - sctrl_ch>=NUM_CH returns 0.
- sctrl_count is combinational from the count registers, range 0..DEPTH.

Test Plan:
- Reset then sctrl_en=2'b01, ch0 ready every 16th cycle with data=i (DEPTH=512, mode 0) -> sensor_en=2'b01 one cycle after en; after 512 samples count0=512, sensor_en[0]=0, irq=2'b01 next cycle; readout ch0 addr k returns k one cycle later.
- Mode 1, sctrl_wm=100, both channels enabled, ch1 ready every cycle, ch0 every 3rd cycle -> irq[1] one cycle after the 100th ch1 sample; irq[0] only after the 100th ch0 sample; banks hold independent sequences.
- Ch0 FULL, pulse sensor_ready[0] with 0xDEAD -> sample not stored, ovf[0]=1. sctrl_clear[0] -> count0=0, ovf0=0, irq0=0, FILL resumes next cycle.
- sctrl_clear[1] and sensor_ready[1] in the same cycle at count1=37 -> count1=0, word 37 unchanged, ovf1=0.
- Drop sctrl_en[0] at count0=200, then re-assert -> sensor_en[0] low while disabled, ready ignored, capture resumes at addr 200.
- Assert rstn=0 asynchronously mid-fill (count=300) -> all outputs 0 immediately; after release count=0, IDLE.
